// File: rtl/vx_gpr_bank_arb_pkg.sv
// Shared GPR banking definitions for the operand-collector read arbiter.
// Holds the bank-count default, the bank-bit computation and the helper that
// splits a register index into (bank, bank-local address).
package vx_gpr_bank_arb_pkg;

    localparam int NUM_GPR_BANKS = 4;

    // Result of splitting a register index; fields are wide and get trimmed
    // by the user to its own BANK_BITS / address width.
    typedef struct packed {
        logic [31:0] bank;
        logic [31:0] addr;
    } gpr_split_t;

    // log2 of the bank count, 0 for a single bank.
    function automatic int gpr_bank_bits(input int num_banks);
        if (num_banks > 1) begin
            return $clog2(num_banks);
        end else begin
            return 0;
        end
    endfunction

    // Low BANK_BITS select the bank, the remaining upper bits address it.
    function automatic gpr_split_t gpr_split(input logic [31:0] reg_idx, input int bank_bits);
        gpr_split_t res;
        if (bank_bits == 0) begin
            res.bank = 32'd0;
            res.addr = reg_idx;
        end else begin
            res.bank = reg_idx & ((32'd1 << bank_bits) - 32'd1);
            res.addr = reg_idx >> bank_bits;
        end
        return res;
    endfunction

endpackage

// File: rtl/vx_gpr_bank_rr.sv
// Per-bank round-robin grant unit.
// Ports: clk, reset (async, active-low), req_mask (requesters targeting this
// bank), block (bank taken by writeback), grant (one-hot, combinational).
// The pointer names the requester with highest priority next; it advances
// past the winner on every grant and is otherwise held.
module vx_gpr_bank_rr #(
    parameter int NUM_REQS = 4,
    localparam int PTR_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_mask,
    input  logic                block,
    output logic [NUM_REQS-1:0] grant
);

    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] rr_ptr_nxt_s;

    // Scan requesters starting at the pointer; first hit wins.
    always_comb begin
        logic [NUM_REQS-1:0] mask_v;
        logic                found_v;
        logic                take_v;
        int                  idx_v;
        grant        = '0;
        rr_ptr_nxt_s = rr_ptr_r;
        found_v      = 1'b0;
        take_v       = 1'b0;
        idx_v        = 0;
        mask_v       = block ? '0 : req_mask;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx_v        = (int'(rr_ptr_r) + k) % NUM_REQS;
            take_v       = !found_v && mask_v[idx_v];
            grant[idx_v] = grant[idx_v] | take_v;
            rr_ptr_nxt_s = take_v ? PTR_W'((idx_v + 1) % NUM_REQS) : rr_ptr_nxt_s;
            found_v      = found_v | take_v;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

endmodule

// File: rtl/vx_gpr_bank_arb.sv
// GPR bank read arbiter.
// Ports: clk, reset (async, active-low); req_valid/req_reg/req_tag/req_ready
// (per-requester read handshake, ready is combinational); wb_valid/wb_reg
// (writeback that owns its bank this cycle); bank_rd_en/bank_rd_addr (bank
// read strobes); rsp_valid/rsp_tag/rsp_bank (one-cycle-delayed response
// info, tag/bank held while not valid); perf_conflicts (cycles in which some
// valid request was left waiting).
// With a single bank the bank fields are kept one bit wide and tied to 0.
module vx_gpr_bank_arb
    import vx_gpr_bank_arb_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int NUM_BANKS = NUM_GPR_BANKS,
    parameter int NR_BITS   = 8,
    parameter int TAG_W     = 2,
    parameter int PERF_W    = 16,
    localparam int BANK_BITS = gpr_bank_bits(NUM_BANKS),
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1,
    localparam int ADDR_W    = NR_BITS - BANK_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*NR_BITS-1:0]   req_reg,
    input  logic [NUM_REQS*TAG_W-1:0]     req_tag,
    output logic [NUM_REQS-1:0]           req_ready,
    input  logic                          wb_valid,
    input  logic [NR_BITS-1:0]            wb_reg,
    output logic [NUM_BANKS-1:0]          bank_rd_en,
    output logic [NUM_BANKS*ADDR_W-1:0]   bank_rd_addr,
    output logic [NUM_REQS-1:0]           rsp_valid,
    output logic [NUM_REQS*TAG_W-1:0]     rsp_tag,
    output logic [NUM_REQS*BANK_W-1:0]    rsp_bank,
    output logic [PERF_W-1:0]             perf_conflicts
);

    logic [BANK_W-1:0]   req_bank_s  [NUM_REQS];
    logic [ADDR_W-1:0]   req_addr_s  [NUM_REQS];
    logic [BANK_W-1:0]   wb_bank_s;
    logic [NUM_REQS-1:0] bank_mask_s [NUM_BANKS];
    logic [NUM_REQS-1:0] grant_s     [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_block_s;

    // Split every request and the writeback index into bank and address.
    always_comb begin
        gpr_split_t split_v;
        split_v   = gpr_split(32'(wb_reg), BANK_BITS);
        wb_bank_s = split_v.bank[BANK_W-1:0];
        for (int i = 0; i < NUM_REQS; i++) begin
            split_v       = gpr_split(32'(req_reg[i*NR_BITS +: NR_BITS]), BANK_BITS);
            req_bank_s[i] = split_v.bank[BANK_W-1:0];
            req_addr_s[i] = split_v.addr[ADDR_W-1:0];
        end
    end

    // Per-bank request masks; a writeback-owned bank is blocked.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_block_s[b] = wb_valid && (wb_bank_s == BANK_W'(b));
            for (int i = 0; i < NUM_REQS; i++) begin
                bank_mask_s[b][i] = req_valid[i] && (req_bank_s[i] == BANK_W'(b));
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        vx_gpr_bank_rr #(
            .NUM_REQS (NUM_REQS)
        ) u_rr (
            .clk      (clk),
            .reset    (reset),
            .req_mask (bank_mask_s[gb]),
            .block    (bank_block_s[gb]),
            .grant    (grant_s[gb])
        );
    end

    // Merge per-bank grants into requester readies and bank read ports.
    // Each requester hits exactly one bank, so OR-merging is conflict-free.
    always_comb begin
        req_ready    = '0;
        bank_rd_en   = '0;
        bank_rd_addr = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_rd_en[b] = |grant_s[b];
            for (int i = 0; i < NUM_REQS; i++) begin
                req_ready[i] = req_ready[i] | grant_s[b][i];
                bank_rd_addr[b*ADDR_W +: ADDR_W] = bank_rd_addr[b*ADDR_W +: ADDR_W]
                                                 | ({ADDR_W{grant_s[b][i]}} & req_addr_s[i]);
            end
        end
    end

    // Response pipeline stage and conflict counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid      <= '0;
            rsp_tag        <= '0;
            rsp_bank       <= '0;
            perf_conflicts <= '0;
        end else begin
            rsp_valid <= req_ready;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (req_ready[i]) begin
                    rsp_tag[i*TAG_W +: TAG_W]    <= req_tag[i*TAG_W +: TAG_W];
                    rsp_bank[i*BANK_W +: BANK_W] <= req_bank_s[i];
                end
            end
            if (|(req_valid & ~req_ready)) begin
                perf_conflicts <= perf_conflicts + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vx_gpr_bank_arb.sv
module tb_vx_gpr_bank_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_reg;
    logic [7:0]  req_tag;
    logic [3:0]  req_ready;
    logic        wb_valid;
    logic [7:0]  wb_reg;
    logic [3:0]  bank_rd_en;
    logic [23:0] bank_rd_addr;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_tag;
    logic [7:0]  rsp_bank;
    logic [15:0] perf_conflicts;

    vx_gpr_bank_arb #(
        .NUM_REQS (4), .NUM_BANKS (4), .NR_BITS (8), .TAG_W (2), .PERF_W (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_reg        (req_reg),
        .req_tag        (req_tag),
        .req_ready      (req_ready),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .bank_rd_en     (bank_rd_en),
        .bank_rd_addr   (bank_rd_addr),
        .rsp_valid      (rsp_valid),
        .rsp_tag        (rsp_tag),
        .rsp_bank       (rsp_bank),
        .perf_conflicts (perf_conflicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [7:0]  tags;
        logic [7:0]  banks;
        logic [15:0] perf;
    } exp_t;

    exp_t q[$];

    // reference model state
    int          m_ptr[4];
    logic [7:0]  m_tags;
    logic [7:0]  m_banks;
    logic [15:0] m_perf;
    logic [3:0]  m_ready;
    bit          in_reset;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) m_ptr[b] = 0;
        m_tags  = 8'h00;
        m_banks = 8'h00;
        m_perf  = 16'h0000;
        m_ready = 4'b0000;
        q.delete();
    endtask

    // Monitor: compare registered response side against queued expectations.
    always @(negedge clk) begin
        if (!in_reset && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(e.v));
            check("rsp_tag", 32'(rsp_tag), 32'(e.tags));
            check("rsp_bank", 32'(rsp_bank), 32'(e.banks));
            check("perf_conflicts", 32'(perf_conflicts), 32'(e.perf));
        end
    end

    // Inputs are already applied for this cycle; compute the expected
    // arbitration, check combinational outputs and queue the response.
    task automatic do_cycle();
        logic [3:0]  ev;
        logic [3:0]  een;
        logic [23:0] eaddr;
        int          g;
        int          r;
        int          ii;
        exp_t        e;
        #1;
        ev = 4'b0000; een = 4'b0000; eaddr = 24'h0;
        for (int b = 0; b < 4; b++) begin
            g = -1;
            if (!(wb_valid && (int'(wb_reg) % 4) == b)) begin
                for (int k = 0; k < 4; k++) begin
                    ii = (m_ptr[b] + k) % 4;
                    r  = int'(req_reg[ii*8 +: 8]);
                    if (g < 0 && req_valid[ii] && (r % 4) == b) begin
                        g = ii;
                        ev[ii] = 1'b1;
                        een[b] = 1'b1;
                        eaddr[b*6 +: 6] = 6'(r / 4);
                    end
                end
            end
            if (g >= 0) m_ptr[b] = (g + 1) % 4;
        end
        check("req_ready", 32'(req_ready), 32'(ev));
        check("bank_rd_en", 32'(bank_rd_en), 32'(een));
        for (int b = 0; b < 4; b++) begin
            if (een[b]) check($sformatf("bank_rd_addr%0d", b), 32'(bank_rd_addr[b*6 +: 6]), 32'(eaddr[b*6 +: 6]));
        end
        if ((req_valid & ~ev) != 4'b0000) m_perf = m_perf + 16'd1;
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
                m_tags[i*2 +: 2]  = req_tag[i*2 +: 2];
                m_banks[i*2 +: 2] = 2'(int'(req_reg[i*8 +: 8]) % 4);
            end
        end
        e.v = ev; e.tags = m_tags; e.banks = m_banks; e.perf = m_perf;
        q.push_back(e);
        m_ready = ev;
    endtask

    task automatic drop_fired();
        req_valid = req_valid & ~m_ready;
    endtask

    task automatic set_req(input int i, input logic [7:0] r, input logic [1:0] t);
        req_valid[i]     = 1'b1;
        req_reg[i*8 +: 8] = r;
        req_tag[i*2 +: 2] = t;
    endtask

    // Fire one request on bank 0, reset with a response in flight, then
    // check that the first contention after release goes to requester 0.
    task automatic reset_midflight(input int first);
        @(negedge clk);
        req_valid = 4'b0000; wb_valid = 1'b0;
        set_req(first, 8'h00, 2'd3);
        do_cycle();
        @(posedge clk);
        #2;
        check("rsp_valid_pre_reset", 32'(rsp_valid), 32'(4'b1 << first));
        req_valid = 4'b0000;
        in_reset  = 1'b1;
        reset     = 1'b0;
        model_reset();
        #1;
        check("rsp_valid_async_reset", 32'(rsp_valid), 32'h0);
        check("rsp_tag_async_reset", 32'(rsp_tag), 32'h0);
        check("perf_async_reset", 32'(perf_conflicts), 32'h0);
        repeat (2) @(negedge clk);
        #2;
        reset    = 1'b1;
        in_reset = 1'b0;
        set_req(0, 8'h00, 2'd1);
        set_req(3, 8'h04, 2'd2);
        do_cycle();
        check("post_reset_rr", 32'(req_ready), 32'h1);
        @(negedge clk);
        drop_fired();
        do_cycle();
        check("post_reset_rr2", 32'(req_ready), 32'h8);
        @(negedge clk);
        drop_fired();
        do_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] base;
        reset = 1'b0; in_reset = 1'b1;
        req_valid = 4'b0000; req_reg = 32'h0; req_tag = 8'h0;
        wb_valid = 1'b0; wb_reg = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_perf", 32'(perf_conflicts), 32'h0);
        #2;
        reset = 1'b1; in_reset = 1'b0;

        // single request to bank 1
        set_req(0, 8'h05, 2'd2);
        do_cycle();
        check("d1_ready", 32'(req_ready), 32'h1);
        check("d1_en", 32'(bank_rd_en), 32'h2);
        check("d1_addr", 32'(bank_rd_addr[11:6]), 32'h1);
        @(negedge clk);
        check("d1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("d1_rsp_tag", 32'(rsp_tag[1:0]), 32'h2);
        check("d1_rsp_bank", 32'(rsp_bank[1:0]), 32'h1);
        req_valid = 4'b0000;
        do_cycle();

        // four requesters contend on bank 2
        base = m_perf;
        @(negedge clk);
        set_req(0, 8'h02, 2'd0); set_req(1, 8'h06, 2'd1);
        set_req(2, 8'h0A, 2'd2); set_req(3, 8'h0E, 2'd3);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                drop_fired();
            end
            do_cycle();
            check("d2_order", 32'(req_ready), 32'(4'b1 << k));
        end
        @(negedge clk);
        check("d2_perf", 32'(perf_conflicts), 32'(base + 16'd3));
        drop_fired();
        do_cycle();

        // writeback blocks bank 2
        @(negedge clk);
        wb_valid = 1'b1; wb_reg = 8'h06;
        set_req(1, 8'h0A, 2'd1);
        do_cycle();
        check("d3_ready_blocked", 32'(req_ready), 32'h0);
        check("d3_en2", 32'(bank_rd_en[2]), 32'h0);
        @(negedge clk);
        wb_valid = 1'b0;
        do_cycle();
        check("d3_ready_free", 32'(req_ready), 32'h2);
        @(negedge clk);
        drop_fired();

        // all banks in parallel
        set_req(0, 8'h00, 2'd3); set_req(1, 8'h01, 2'd2);
        set_req(2, 8'h02, 2'd1); set_req(3, 8'h03, 2'd0);
        do_cycle();
        check("d4_ready", 32'(req_ready), 32'hF);
        check("d4_en", 32'(bank_rd_en), 32'hF);
        check("d4_addr", 32'(bank_rd_addr), 32'h0);
        @(negedge clk);
        drop_fired();
        do_cycle();

        reset_midflight(3);

        // randomized traffic with hold-until-fire requesters
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drop_fired();
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom % 2) == 0) begin
                    set_req(i, 8'($urandom), 2'($urandom));
                end
            end
            wb_valid = (($urandom % 4) == 0);
            wb_reg   = 8'($urandom);
            do_cycle();
        end
        @(negedge clk);
        drop_fired();
        wb_valid = 1'b0;
        req_valid = 4'b0000;
        do_cycle();

        // pointer moved away from 0 before the reset this time
        reset_midflight(1);

        @(negedge clk);
        req_valid = 4'b0000;
        do_cycle();
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
